// File: rtl/cpu_bus_responder_if.sv
// CPU bus, ROM load port and write-trace port of cpu_bus_responder.
// slave = responder side, master = CPU / load / trace-consumer side.
interface cpu_bus_responder_if;
    logic [15:0] i_address;
    logic        i_rw;
    logic [7:0]  i_data;
    logic [7:0]  o_data;
    logic        o_rdy;
    logic        i_load_we;
    logic [7:0]  i_load_addr;
    logic [7:0]  i_load_data;
    logic        o_trace_valid;
    logic [23:0] o_trace_data;
    logic        i_trace_ready;
    logic        o_trace_overflow;

    modport slave (
        input  i_address, i_rw, i_data, i_load_we, i_load_addr, i_load_data, i_trace_ready,
        output o_data, o_rdy, o_trace_valid, o_trace_data, o_trace_overflow
    );

    modport master (
        output i_address, i_rw, i_data, i_load_we, i_load_addr, i_load_data, i_trace_ready,
        input  o_data, o_rdy, o_trace_valid, o_trace_data, o_trace_overflow
    );
endinterface

// File: rtl/cpu_bus_responder.sv
// CPU bus responder: 2 KB mirrored RAM, 256-byte ROM with read wait states, open bus elsewhere.
// Define BUS_RESPONDER_TRACE_EN to build the write-trace FIFO; otherwise trace outputs are tied low.
module cpu_bus_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned TRACE_DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    cpu_bus_responder_if.slave bus
);
    localparam int unsigned RAM_AW  = 11;
    localparam int unsigned ROM_AW  = 8;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned TRACE_W = 24;

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         data_q;
    logic               rdy_c;
    logic               accept_c;
    logic               is_ram_c;
    logic               is_rom_c;

    logic [7:0] ram [2**RAM_AW];
    logic [7:0] rom [2**ROM_AW];

    assign is_ram_c = (bus.i_address[15:13] == 3'b000);
    assign is_rom_c = bus.i_address[15];

    // Stall only ROM reads; WAIT holds the stalled cycle until the counter drains.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_c   = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (is_rom_c && bus.i_rw && (WAIT_CYCLES != 0)) begin
                    rdy_c   = 1'b0;
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    rdy_c = 1'b0;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset forces ready high so a stalled cycle is released immediately.
    assign bus.o_rdy = rdy_c | ~i_reset_n;
    assign accept_c  = rdy_c & i_reset_n;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept_c && bus.i_rw) begin
                if (is_ram_c) begin
                    data_q <= ram[bus.i_address[RAM_AW-1:0]];
                end else if (is_rom_c) begin
                    data_q <= rom[bus.i_address[ROM_AW-1:0]];
                end
            end
        end
    end

    assign bus.o_data = data_q;

    // Memory arrays survive reset; ROM is only written through the load port.
    always_ff @(posedge i_clk) begin
        if (accept_c && !bus.i_rw && is_ram_c) begin
            ram[bus.i_address[RAM_AW-1:0]] <= bus.i_data;
        end
        if (bus.i_load_we) begin
            rom[bus.i_load_addr] <= bus.i_load_data;
        end
    end

`ifdef BUS_RESPONDER_TRACE_EN
    localparam int unsigned TP_W = $clog2(TRACE_DEPTH);
    localparam int unsigned TC_W = TP_W + 1;

    logic [TRACE_W-1:0] tmem [TRACE_DEPTH];
    logic [TP_W-1:0]    wr_q, rd_q;
    logic [TC_W-1:0]    tcnt_q;
    logic               ovf_q;
    logic               push_c, pop_c, full_c, push_ok_c;

    assign push_c    = accept_c && !bus.i_rw;
    assign pop_c     = (tcnt_q != '0) && bus.i_trace_ready;
    assign full_c    = (tcnt_q == TC_W'(TRACE_DEPTH));
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign push_ok_c = push_c && (!full_c || pop_c);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            tcnt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_q <= wr_q + TP_W'(1);
            end
            if (pop_c) begin
                rd_q <= rd_q + TP_W'(1);
            end
            case ({push_ok_c, pop_c})
                2'b10:   tcnt_q <= tcnt_q + TC_W'(1);
                2'b01:   tcnt_q <= tcnt_q - TC_W'(1);
                default: tcnt_q <= tcnt_q;
            endcase
            if (push_c && !push_ok_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok_c) begin
            tmem[wr_q] <= {bus.i_address, bus.i_data};
        end
    end

    assign bus.o_trace_valid    = (tcnt_q != '0);
    assign bus.o_trace_data     = tmem[rd_q];
    assign bus.o_trace_overflow = ovf_q;
`else
    logic unused_trace;

    assign unused_trace         = ^{bus.i_trace_ready, bus.i_address[12:11]};
    assign bus.o_trace_valid    = 1'b0;
    assign bus.o_trace_data     = '0;
    assign bus.o_trace_overflow = 1'b0;
`endif

endmodule
